// File: rtl/ex_commit.sv
// Commit/writeback stage: one hold buffer per execute unit, round-robin grant onto the single RF write port.
// Results reach rf_w* two cycles after transfer; a unit is stalled only while its buffered result waits for a grant.
module ex_commit #(
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_UNITS-1:0]    ex_valid,
  input  logic [6*NUM_UNITS-1:0]  ex_rn,
  input  logic [64*NUM_UNITS-1:0] ex_data,
  output logic [NUM_UNITS-1:0]    ex_stall,
  output logic                    rf_we,
  output logic [5:0]              rf_wa,
  output logic [63:0]             rf_wd,
  output logic [CNT_W-1:0]        retired
);

  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] hv_q, hv_d;
  logic [5:0]           hrn_q   [NUM_UNITS];
  logic [5:0]           hrn_d   [NUM_UNITS];
  logic [63:0]          hdata_q [NUM_UNITS];
  logic [63:0]          hdata_d [NUM_UNITS];
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 rf_we_q, rf_we_d;
  logic [5:0]           rf_wa_q, rf_wa_d;
  logic [63:0]          rf_wd_q, rf_wd_d;
  logic [CNT_W-1:0]     retired_q, retired_d;

  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] xfer;
  logic                 gnt_any;
  logic [PW-1:0]        gnt_idx;
  logic [5:0]           sel_rn;
  logic [63:0]          sel_data;

  // Round-robin: first holding unit at distance 1..NUM_UNITS from the last grant wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (!gnt_any && hv_q[i] && (i == ((int'(ptr_q) + k) % NUM_UNITS))) begin
          grant[i] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = PW'(i);
        end
      end
    end
  end

  assign ex_stall = hv_q & ~grant;
  assign xfer     = ex_valid & ~ex_stall;

  always_comb begin
    sel_rn   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        sel_rn   = hrn_q[i];
        sel_data = hdata_q[i];
      end
    end
  end

  // A captured result may overwrite the entry being drained in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      hv_d[i]    = xfer[i] | (hv_q[i] & ~grant[i]);
      hrn_d[i]   = xfer[i] ? ex_rn[6*i +: 6]    : hrn_q[i];
      hdata_d[i] = xfer[i] ? ex_data[64*i +: 64] : hdata_q[i];
    end
    ptr_d     = gnt_any ? gnt_idx : ptr_q;
    rf_we_d   = gnt_any && (sel_rn != 6'd0);
    rf_wa_d   = gnt_any ? sel_rn   : rf_wa_q;
    rf_wd_d   = gnt_any ? sel_data : rf_wd_q;
    retired_d = gnt_any ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q      <= '0;
      ptr_q     <= PW'(NUM_UNITS - 1);
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      retired_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        hrn_q[i]   <= '0;
        hdata_q[i] <= '0;
      end
    end else begin
      hv_q      <= hv_d;
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_wa_q   <= rf_wa_d;
      rf_wd_q   <= rf_wd_d;
      retired_q <= retired_d;
      for (int i = 0; i < NUM_UNITS; i++) begin
        hrn_q[i]   <= hrn_d[i];
        hdata_q[i] <= hdata_d[i];
      end
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ex_commit.sv
// Directed bench for ex_commit: inputs driven and outputs sampled on the falling edge.
module tb_ex_commit;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    ex_valid;
  logic [6*N-1:0]  ex_rn;
  logic [64*N-1:0] ex_data;
  logic [N-1:0]    ex_stall;
  logic            rf_we;
  logic [5:0]      rf_wa;
  logic [63:0]     rf_wd;
  logic [CW-1:0]   retired;

  int n_tests = 0;
  int n_fail  = 0;

  ex_commit #(.NUM_UNITS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rn(ex_rn), .ex_data(ex_data),
    .ex_stall(ex_stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic v, input logic [5:0] rn, input logic [63:0] d);
    ex_valid[u]       = v;
    ex_rn[6*u +: 6]   = rn;
    ex_data[64*u +: 64] = d;
  endtask

  task automatic do_reset();
    ex_valid = '0;
    ex_rn    = '0;
    ex_data  = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int j, k0, k2, run0, run2, max0, max2, nw;
    logic [N-1:0] prev_stall;
    logic [5:0] wr [$];

    do_reset();
    chk("rst_stall", ex_stall, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_retired", retired, 0);

    // 1: single unit back-to-back
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("t1_stall0", ex_stall[0], 0);
      if (n >= 2 && n <= 5) begin
        chk("t1_we", rf_we, 1);
        chk("t1_wa", rf_wa, 6'(n - 1));
        chk("t1_wd", rf_wd, 64'((n - 1) * 'h11));
      end else begin
        chk("t1_we_idle", rf_we, 0);
      end
      if (n < 4) drive(0, 1'b1, 6'(n + 1), 64'((n + 1) * 'h11));
      else       drive(0, 1'b0, 6'd0, 64'd0);
    end
    chk("t1_retired", retired, 4);

    // 2: all-unit contention
    do_reset();
    @(negedge clk);
    for (int u = 0; u < N; u++) drive(u, 1'b1, 6'(10 + u), 64'h100 + 64'(u));
    @(negedge clk);
    ex_valid = '0;
    chk("t2_stall_c0", ex_stall, 4'b1110);
    chk("t2_we_c0", rf_we, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t2_stall", ex_stall, 4'((4'b1110 << c) & 4'hF));
      chk("t2_we", rf_we, 1);
      chk("t2_wa", rf_wa, 6'(9 + c));
      chk("t2_wd", rf_wd, 64'h100 + 64'(c - 1));
    end
    @(negedge clk);
    chk("t2_we_end", rf_we, 0);
    chk("t2_retired", retired, 4);

    // 3: round-robin fairness between units 0 and 2
    do_reset();
    j = 0; k0 = 0; k2 = 0; run0 = 0; run2 = 0; max0 = 0; max2 = 0;
    prev_stall = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (rf_we) begin
        chk("t3_wa", rf_wa, (j % 2 == 0) ? 6'(j / 2 + 1) : 6'(16 + j / 2 + 1));
        chk("t3_wd", rf_wd, 64'h3000 + ((j % 2 == 0) ? 64'd0 : 64'h200) + 64'(j / 2));
        j++;
      end
      if (ex_valid[0] && !prev_stall[0]) k0++;
      if (ex_valid[2] && !prev_stall[2]) k2++;
      run0 = ex_stall[0] ? run0 + 1 : 0;
      run2 = ex_stall[2] ? run2 + 1 : 0;
      if (run0 > max0) max0 = run0;
      if (run2 > max2) max2 = run2;
      if (n < 10) begin
        drive(0, 1'b1, 6'(k0 + 1), 64'h3000 + 64'(k0));
        drive(2, 1'b1, 6'(16 + k2 + 1), 64'h3200 + 64'(k2));
      end else begin
        ex_valid = '0;
      end
      prev_stall = ex_stall;
    end
    chk("t3_commits", j, 11);
    chk("t3_retired", retired, 11);
    chk("t3_wait0", max0, 1);
    chk("t3_wait2", max2, 1);

    // 4: r0 discard
    do_reset();
    @(negedge clk);
    drive(1, 1'b1, 6'd0, 64'hDEAD);
    @(negedge clk);
    ex_valid = '0;
    chk("t4_stall1", ex_stall[1], 0);
    chk("t4_we_c0", rf_we, 0);
    @(negedge clk);
    chk("t4_we", rf_we, 0);
    chk("t4_retired", retired, 1);

    // 5: reset mid-operation
    do_reset();
    @(negedge clk);
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 6'(30 + u), 64'h500 + 64'(u));
    @(negedge clk);
    ex_valid = '0;
    @(negedge clk);
    chk("t5_pre_we", rf_we, 1);
    chk("t5_pre_stall", ex_stall, 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_stall", ex_stall, 0);
    chk("t5_rst_we", rf_we, 0);
    chk("t5_rst_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 6'd40, 64'h40);
    drive(3, 1'b1, 6'd43, 64'h43);
    wr.delete();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      ex_valid = '0;
      if (rf_we) wr.push_back(rf_wa);
    end
    nw = wr.size();
    chk("t5_nwrites", nw, 2);
    if (nw >= 2) begin
      chk("t5_first", wr[0], 40);
      chk("t5_second", wr[1], 43);
    end

    // 6: counter wrap with a 4-bit counter
    do_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n < 17) drive(0, 1'b1, 6'(n + 1), 64'(n));
      else        drive(0, 1'b0, 6'd0, 64'd0);
    end
    @(negedge clk);
    chk("t6_retired", retired, 1);
    chk("t6_last_wa", rf_wa, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_commit.md
Name: ex_commit

Overview:
Commit/writeback stage on the far end of the execute-unit result interface. Accepts results from NUM_UNITS execute units over a valid/stall handshake and buffers one result per unit. Grants one result per cycle by round-robin and drives the single integer register-file write port. Back-pressures each unit through its stall line.

Parameters:
NUM_UNITS, 4, number of execute units attached (2..8)
CNT_W, 32, width of the retired-result counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  NUM_UNITS  per-unit result valid (unit i on bit i)
ex_rn  in  6*NUM_UNITS  per-unit destination register; unit i on bits [6i+5:6i]
ex_data  in  64*NUM_UNITS  per-unit result data; unit i on bits [64i+63:64i]
ex_stall  out  NUM_UNITS  per-unit stall back to the unit
rf_we  out  1  register-file write enable
rf_wa  out  6  register-file write address
rf_wd  out  64  register-file write data
retired  out  CNT_W  count of results committed, including r0 discards

Behaviour:
- Clock and reset: clk, rst_n asynchronous active-low. Reset clears all hold buffers. Reset values: ex_stall=0, rf_we=0, rf_wa=0, rf_wd=0, retired=0. Round-robin pointer resets to NUM_UNITS-1, so unit 0 has first priority.
- Handshake: unit i transfers a result at a rising edge where ex_valid[i]=1 and ex_stall[i]=0. The unit holds ex_valid, ex_rn and ex_data stable while ex_stall[i]=1. With ex_valid[i]=0, the inputs are ignored.
- Hold buffer: one entry per unit (hv[i], hrn[i], hdata[i]).
  - The buffer captures when the transfer condition holds.
  - Capture and drain of the same entry in the same cycle is legal. The new result replaces the drained one and hv stays 1.
- Stall: ex_stall[i] = hv[i] & ~grant[i].
  - Combinational from registered state only.
  - No combinational path from ex_valid, ex_rn or ex_data to ex_stall.
- Arbitration: grant is one-hot among units with hv=1.
  - Search starts at pointer+1 and wraps modulo NUM_UNITS.
  - On any grant, the pointer is set to the granted index.
  - With no hv set, there is no grant and the pointer is unchanged.
- Writeback: registered outputs.
  - On the edge ending a grant cycle: rf_we=(hrn!=0), rf_wa=hrn, rf_wd=hdata of the granted unit, and retired increments by 1 (wraps at 2^CNT_W).
  - A grant with rn=0 is consumed and counted but not written; rf_we=0.
  - With no grant: rf_we=0, and rf_wa and rf_wd hold their last values.
- Latency and throughput:
  - Result transferred at edge E appears on rf_w* during the cycle after edge E+1, i.e. 2 cycles after transfer.
  - One commit per cycle in aggregate.
  - A lone active unit sustains 1 result per cycle with ex_stall always 0.
- Contention: with K units holding, each waits at most K-1 cycles. No starvation.
- Reset mid-operation: buffered results are discarded, and rf_we drops to 0 immediately (asynchronously).

Test Plan:
1. Single unit back-to-back:
   - Stimulus: unit 0 ex_valid=1 for 4 cycles with (rn,data) = (1,0x11), (2,0x22), (3,0x33), (4,0x44).
   - Required: ex_stall[0] stays 0; rf_we=1 on 4 consecutive cycles, starting 2 cycles after the first transfer, with exactly those pairs in order; retired=4.
2. All-unit contention:
   - Stimulus: all 4 units valid in the same cycle, rn=10..13.
   - Required: writes occur in order rn 10, 11, 12, 13 on consecutive cycles. Units 1, 2 and 3 see ex_stall for 1, 2 and 3 cycles respectively, and each unit's held data stays intact.
3. Round-robin fairness:
   - Stimulus: units 0 and 2 valid continuously for 10 cycles.
   - Required: commits alternate 0, 2, 0, 2…; neither unit waits more than 1 cycle for a grant.
4. r0 discard:
   - Stimulus: unit 1 sends rn=0, data=0xDEAD.
   - Required: rf_we stays 0 for that slot; retired increments by 1; ex_stall[1] stays 0.
5. Reset mid-operation:
   - Stimulus: 3 units holding results, then rst_n pulsed low for 1 cycle.
   - Required: immediately ex_stall=0, rf_we=0, retired=0. After release, the first grant goes to unit 0 and no pre-reset result is ever written.
6. Counter wrap:
   - Stimulus: CNT_W=4, 17 results.
   - Required: retired reads 1 at the end.
